// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the hazard controller and the
// datapath operand muxes.
//   FWD_*        : 2-bit operand-select codes (register file, EX ALU,
//                  MEM ALU, MEM load data)
//   stage_info_t : per-stage tracker record {v, wr, ld, dst}
//   stage_match  : whether a tracked stage produces a given ID source
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_LD  = 2'b11;

    typedef struct packed {
        logic       v;    // stage holds a real instruction
        logic       wr;   // instruction writes the register file
        logic       ld;   // instruction is a load (value only ready after MEM)
        logic [4:0] dst;  // destination register
    } stage_info_t;

    localparam stage_info_t STAGE_NONE = '0;

    // $0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic stage_match(input stage_info_t s,
                                         input logic [4:0]  src,
                                         input logic        use_src);
        return s.v && s.wr && (s.dst == src) && (src != 5'd0) && use_src;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: forwarding select for one ID-stage source operand.
//   ex, mem  : tracker records of the EX and MEM stages
//   src      : source register number, use_src: operand is actually read
//   fwd      : operand select (FWD_* codes)
//   ld_hit   : EX holds a load producing this operand (load-use hazard)
module hazard_fwd_sel
    import mips_pkg::*;
(
    input  stage_info_t ex,
    input  stage_info_t mem,
    input  logic [4:0]  src,
    input  logic        use_src,
    output logic [1:0]  fwd,
    output logic        ld_hit
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit  = stage_match(ex, src, use_src);
        mem_hit = stage_match(mem, src, use_src);
        ld_hit  = ex_hit & ex.ld;
        fwd     = FWD_RF;
        // The youngest producer wins. A load still in EX has no data yet, so
        // the select stays on the register file while the stall takes effect.
        if (ex_hit)
            fwd = ex.ld ? FWD_RF : FWD_EX;
        else if (mem_hit)
            fwd = mem.ld ? FWD_LD : FWD_MEM;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS32 core.
// Tracks EX/MEM destination info and drives forwarding selects, load-use
// stall, data-memory freeze and IF/ID flush.
//   clk, rst                 : core clock, async active-high reset
//   id_*                     : ID-stage instruction fields
//   mem_busy                 : data memory not ready for the MEM access
//   writepc, writeir         : PC / IF-ID load enables
//   bubble                   : ID/EX loads a NOP
//   freeze                   : ID/EX, EX/MEM, MEM/WB hold
//   flush_if                 : IF/ID loads a NOP
//   fwda, fwdb               : rs / rt operand selects
//   stall_cnt                : saturating count of cycles with writepc=0
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   id_writereg,
    input  logic                   id_readmem,
    input  logic [4:0]             id_dest,
    input  logic                   id_branch_taken,
    input  logic                   id_jump,
    input  logic                   mem_busy,
    output logic                   writepc,
    output logic                   writeir,
    output logic                   bubble,
    output logic                   freeze,
    output logic                   flush_if,
    output logic [1:0]             fwda,
    output logic [1:0]             fwdb,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int NUM_OPS = 2;  // operand 0 = rs, operand 1 = rt
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    stage_info_t                  ex_q, mem_q;
    stage_info_t                  id_info;
    logic [NUM_OPS-1:0][4:0]      op_src;
    logic [NUM_OPS-1:0]           op_use;
    logic [NUM_OPS-1:0][1:0]      op_fwd;
    logic [NUM_OPS-1:0]           op_ld_hit;
    logic                         frz;
    logic                         lu;

    assign op_src  = {id_rt, id_rs};
    assign op_use  = {id_use_rt, id_use_rs};
    assign id_info = '{v: id_valid, wr: id_writereg, ld: id_readmem, dst: id_dest};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        hazard_fwd_sel u_sel (
            .ex      (ex_q),
            .mem     (mem_q),
            .src     (op_src[i]),
            .use_src (op_use[i]),
            .fwd     (op_fwd[i]),
            .ld_hit  (op_ld_hit[i])
        );
    end

    // A busy memory only matters when MEM actually holds an access.
    assign frz = mem_busy & mem_q.v;
    assign lu  = id_valid & (|op_ld_hit);

    always_comb begin
        writepc  = 1'b0;
        writeir  = 1'b0;
        bubble   = 1'b0;
        freeze   = 1'b0;
        flush_if = 1'b0;
        fwda     = FWD_RF;
        fwdb     = FWD_RF;
        if (!rst) begin
            fwda   = op_fwd[0];
            fwdb   = op_fwd[1];
            freeze = frz;
            if (frz) begin
                // everything holds; lu and flush are re-evaluated afterwards
            end else if (lu) begin
                bubble = 1'b1;
            end else begin
                writepc  = 1'b1;
                writeir  = 1'b1;
                flush_if = id_valid & (id_branch_taken | id_jump);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= STAGE_NONE;
            mem_q     <= STAGE_NONE;
            stall_cnt <= '0;
        end else begin
            if (!frz) begin
                mem_q <= ex_q;
                ex_q  <= lu ? STAGE_NONE : id_info;
            end
            if ((frz || lu) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule
